// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Collects completed results from the four execution units (int, mul, div,
// ls) and publishes one tag/result per cycle on the Common Data Bus.
// Round-robin arbitration: the search starts at ptr_r, and after a transfer
// from unit k the next search starts at k+1. Grants are combinational. The
// CDB outputs are registered, so the winner of cycle N is on the bus in N+1.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous reset, active low
//   <u>_valid           unit u has a completed result (u = int, mul, div, ls)
//   <u>_tag / _data     result tag and value; held stable until granted
//   <u>_rd_write        result writes a destination register
//   <u>_grant           result accepted this cycle
//   cdb_valid           bus carries a result this cycle
//   cdb_tag/data        published tag and result (held while cdb_valid=0)
//   cdb_rd_write        winner's rd_write
//   cdb_src             winner index: 0 int, 1 mul, 2 div, 3 ls

module cdb_arbiter #(
    parameter int W_DATA = 32,
    parameter int W_TAG  = 6
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              int_valid,
    input  logic [W_TAG-1:0]  int_tag,
    input  logic [W_DATA-1:0] int_data,
    input  logic              int_rd_write,
    output logic              int_grant,

    input  logic              mul_valid,
    input  logic [W_TAG-1:0]  mul_tag,
    input  logic [W_DATA-1:0] mul_data,
    input  logic              mul_rd_write,
    output logic              mul_grant,

    input  logic              div_valid,
    input  logic [W_TAG-1:0]  div_tag,
    input  logic [W_DATA-1:0] div_data,
    input  logic              div_rd_write,
    output logic              div_grant,

    input  logic              ls_valid,
    input  logic [W_TAG-1:0]  ls_tag,
    input  logic [W_DATA-1:0] ls_data,
    input  logic              ls_rd_write,
    output logic              ls_grant,

    output logic              cdb_valid,
    output logic [W_TAG-1:0]  cdb_tag,
    output logic [W_DATA-1:0] cdb_data,
    output logic              cdb_rd_write,
    output logic [1:0]        cdb_src
);

    logic [1:0]        ptr_r;
    logic [3:0]        valid_vec;
    logic [3:0]        grant_vec;
    logic [1:0]        win_idx;
    logic [1:0]        idx;
    logic              found;
    logic              any_grant;
    logic [W_TAG-1:0]  win_tag;
    logic [W_DATA-1:0] win_data;
    logic              win_rd_write;

    assign valid_vec = {ls_valid, div_valid, mul_valid, int_valid};

    // First valid requester at or after ptr_r, wrapping modulo 4.
    always_comb begin
        found   = 1'b0;
        win_idx = 2'd0;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_r + 2'(i);
            if (!found && valid_vec[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Reset gates the grants directly so nothing is accepted while the
    // registered side is being cleared.
    assign any_grant = found & reset;

    always_comb begin
        grant_vec = 4'b0000;
        if (any_grant) begin
            grant_vec[win_idx] = 1'b1;
        end
    end

    assign int_grant = grant_vec[0];
    assign mul_grant = grant_vec[1];
    assign div_grant = grant_vec[2];
    assign ls_grant  = grant_vec[3];

    always_comb begin
        win_tag      = int_tag;
        win_data     = int_data;
        win_rd_write = int_rd_write;
        case (win_idx)
            2'd1: begin
                win_tag      = mul_tag;
                win_data     = mul_data;
                win_rd_write = mul_rd_write;
            end
            2'd2: begin
                win_tag      = div_tag;
                win_data     = div_data;
                win_rd_write = div_rd_write;
            end
            2'd3: begin
                win_tag      = ls_tag;
                win_data     = ls_data;
                win_rd_write = ls_rd_write;
            end
            default: ;
        endcase
    end

    // Payload registers only load on a grant, so they hold their last value
    // while cdb_valid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r        <= 2'd0;
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            cdb_rd_write <= 1'b0;
            cdb_src      <= 2'd0;
        end else if (any_grant) begin
            ptr_r        <= win_idx + 2'd1;
            cdb_valid    <= 1'b1;
            cdb_tag      <= win_tag;
            cdb_data     <= win_data;
            cdb_rd_write <= win_rd_write;
            cdb_src      <= win_idx;
        end else begin
            cdb_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic        clk;
    logic        reset;
    logic        v   [4];
    logic [5:0]  tg  [4];
    logic [31:0] dt  [4];
    logic        rw  [4];
    logic        int_grant, mul_grant, div_grant, ls_grant;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_rd_write;
    logic [1:0]  cdb_src;
    logic [3:0]  gvec;
    logic [3:0]  vbits;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.W_DATA(32), .W_TAG(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .int_valid    (v[0]),  .int_tag (tg[0]), .int_data (dt[0]), .int_rd_write (rw[0]), .int_grant (int_grant),
        .mul_valid    (v[1]),  .mul_tag (tg[1]), .mul_data (dt[1]), .mul_rd_write (rw[1]), .mul_grant (mul_grant),
        .div_valid    (v[2]),  .div_tag (tg[2]), .div_data (dt[2]), .div_rd_write (rw[2]), .div_grant (div_grant),
        .ls_valid     (v[3]),  .ls_tag  (tg[3]), .ls_data  (dt[3]), .ls_rd_write  (rw[3]), .ls_grant  (ls_grant),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_rd_write (cdb_rd_write),
        .cdb_src      (cdb_src)
    );

    assign gvec  = {ls_grant, div_grant, mul_grant, int_grant};
    assign vbits = {v[3], v[2], v[1], v[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_grant;
        logic       exp_cv;
        logic [5:0] exp_tag;
        logic [1:0] exp_src;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [41:0] cdb_bundle(input logic cv, input logic [5:0] t, input logic [1:0] s);
        logic [31:0] d;
        d = (t == 6'd0) ? 32'd0 : 32'hD000_0000 + {26'd0, t};
        return {cv, t, s, t[0], d};
    endfunction

    logic [3:0]  g_now;
    logic        got;
    int          waited;
    int          pubs;
    logic [1:0]  ptr_m;
    logic [3:0]  exp_g;
    logic        m_found;
    logic [1:0]  m_idx;
    logic        pend_v;
    logic [41:0] pend;
    logic [5:0]  tag_ctr;

    initial begin
        // valid | grant | cdb_valid | cdb_tag | cdb_src  (cdb columns reflect the previous row's grant)
        vecs[0]  = '{4'b0001, 4'b0001, 1'b0, 6'd0, 2'd0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 6'd1, 2'd0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 6'd1, 2'd0};
        vecs[3]  = '{4'b1111, 4'b0010, 1'b0, 6'd1, 2'd0};
        vecs[4]  = '{4'b1111, 4'b0100, 1'b1, 6'd2, 2'd1};
        vecs[5]  = '{4'b1111, 4'b1000, 1'b1, 6'd3, 2'd2};
        vecs[6]  = '{4'b1111, 4'b0001, 1'b1, 6'd4, 2'd3};
        vecs[7]  = '{4'b1111, 4'b0010, 1'b1, 6'd1, 2'd0};
        vecs[8]  = '{4'b1111, 4'b0100, 1'b1, 6'd2, 2'd1};
        vecs[9]  = '{4'b1111, 4'b1000, 1'b1, 6'd3, 2'd2};
        vecs[10] = '{4'b1111, 4'b0001, 1'b1, 6'd4, 2'd3};
        vecs[11] = '{4'b0000, 4'b0000, 1'b1, 6'd1, 2'd0};
        vecs[12] = '{4'b1000, 4'b1000, 1'b0, 6'd1, 2'd0};
        vecs[13] = '{4'b1001, 4'b0001, 1'b1, 6'd4, 2'd3};
        vecs[14] = '{4'b1100, 4'b0100, 1'b1, 6'd1, 2'd0};
        vecs[15] = '{4'b0110, 4'b0010, 1'b1, 6'd3, 2'd2};
        vecs[16] = '{4'b0000, 4'b0000, 1'b1, 6'd2, 2'd1};
        vecs[17] = '{4'b0000, 4'b0000, 1'b0, 6'd2, 2'd1};

        for (int k = 0; k < 4; k++) begin
            v[k]  = 1'b0;
            tg[k] = 6'(k + 1);
            dt[k] = 32'hD000_0000 + 32'(k + 1);
            rw[k] = ((k + 1) % 2) == 1;
        end

        reset = 1'b0;
        #2;
        chk("reset_grant", {60'd0, gvec}, 64'd0);
        chk("reset_cdb", {22'd0, cdb_valid, cdb_tag, cdb_src, cdb_rd_write, cdb_data}, {22'd0, 42'd0});
        @(posedge clk); #1;
        reset = 1'b1;

        // Table phase: inputs change just after the edge, checks at +2.
        for (int n = 0; n < 18; n++) begin
            for (int k = 0; k < 4; k++) v[k] = vecs[n].valid[k];
            #1;
            chk($sformatf("grant[%0d]", n), {60'd0, gvec}, {60'd0, vecs[n].exp_grant});
            chk($sformatf("cdb[%0d]", n),
                {22'd0, cdb_valid, cdb_tag, cdb_src, cdb_rd_write, cdb_data},
                {22'd0, cdb_bundle(vecs[n].exp_cv, vecs[n].exp_tag, vecs[n].exp_src)});
            @(posedge clk); #1;
        end

        // Div held behind mul: int grant leaves ptr at mul, then mul wins once
        // and div must win on the following cycle.
        for (int k = 0; k < 4; k++) v[k] = 1'b0;
        v[0] = 1'b1;
        #1;
        chk("pre_int_grant", {60'd0, gvec}, 64'd1);
        @(posedge clk); #1;
        v[0] = 1'b0; v[1] = 1'b1; v[2] = 1'b1; tg[1] = 6'd40; tg[2] = 6'd3;
        got = 1'b0; waited = 99; pubs = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (gvec[2] && !got) begin
                got = 1'b1;
                waited = c;
            end
            g_now = gvec;
            @(posedge clk); #1;
            if (cdb_valid && cdb_src == 2'd2 && cdb_tag == 6'd3) pubs++;
            if (g_now[1]) tg[1] = tg[1] + 6'd1;
            if (g_now[2]) v[2] = 1'b0;
        end
        chk("div_wait_cycles", 64'(waited), 64'd1);
        chk("div_pub_count", 64'(pubs), 64'd1);
        v[1] = 1'b0;
        for (int k = 0; k < 4; k++) tg[k] = 6'(k + 1);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream with ptr_r at 1.
        v[0] = 1'b1;
        @(posedge clk); #2;
        v[0] = 1'b0;
        chk("pre_reset_cv", {63'd0, cdb_valid}, 64'd1);
        for (int k = 0; k < 4; k++) v[k] = 1'b1;
        reset = 1'b0;
        #1;
        chk("async_reset_cv", {63'd0, cdb_valid}, 64'd0);
        chk("async_reset_grant", {60'd0, gvec}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("post_reset_grant", {60'd0, gvec}, 64'd1);
        @(posedge clk); #1;
        chk("post_reset_cdb", {22'd0, cdb_valid, cdb_tag, cdb_src, cdb_rd_write, cdb_data},
            {22'd0, cdb_bundle(1'b1, 6'd1, 2'd0)});

        // Random traffic against a reference arbiter and one-deep scoreboard.
        for (int k = 0; k < 4; k++) v[k] = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        ptr_m = 2'd0; pend_v = 1'b0; pend = '0; tag_ctr = 6'd0;
        for (int n = 0; n < 10000; n++) begin
            #1;
            g_now = gvec;
            m_found = 1'b0; m_idx = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (!m_found && vbits[ptr_m + 2'(i)]) begin
                    m_found = 1'b1;
                    m_idx = ptr_m + 2'(i);
                end
            end
            exp_g = 4'b0000;
            if (m_found) exp_g[m_idx] = 1'b1;
            chk("rand_grant", {60'd0, g_now}, {60'd0, exp_g});
            pend_v = m_found;
            if (m_found) begin
                pend  = {1'b1, tg[m_idx], m_idx, rw[m_idx], dt[m_idx]};
                ptr_m = m_idx + 2'd1;
            end
            @(posedge clk); #1;
            if (pend_v)
                chk("rand_cdb", {22'd0, cdb_valid, cdb_tag, cdb_src, cdb_rd_write, cdb_data}, {22'd0, pend});
            else
                chk("rand_cdb_idle", {63'd0, cdb_valid}, 64'd0);
            for (int k = 0; k < 4; k++) begin
                if (g_now[k] || !v[k]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        v[k]    = 1'b1;
                        tg[k]   = tag_ctr;
                        tag_ctr = tag_ctr + 6'd1;
                        dt[k]   = $urandom;
                        rw[k]   = $urandom_range(0, 1) == 1;
                    end else begin
                        v[k] = 1'b0;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
